// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - IF-stage bundle: hazard/redirect inputs, imem port, IF/ID outputs
interface if_stage_if #(
  parameter int IMEM_AW = 14
);
  logic               WPC;
  logic               ID_stall;
  logic               br_taken;
  logic [31:0]        br_target;
  logic               jmp;
  logic [31:0]        jmp_target;
  logic               exc_req;
  logic               eret;
  logic [31:0]        epc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        ID_inst;
  logic [31:0]        ID_pc_plus4;
  logic               ID_valid;
  logic               IF_adel;

  modport master (
    input  WPC, ID_stall, br_taken, br_target, jmp, jmp_target,
           exc_req, eret, epc, imem_rdata,
    output imem_addr, ID_inst, ID_pc_plus4, ID_valid, IF_adel
  );

  modport slave (
    output WPC, ID_stall, br_taken, br_target, jmp, jmp_target,
           exc_req, eret, epc, imem_rdata,
    input  imem_addr, ID_inst, ID_pc_plus4, ID_valid, IF_adel
  );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - Minisys-1A instruction fetch: PC register, next-PC select, IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_F000,
  parameter int          IMEM_AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  if_stage_if.master    bus
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        redirect;

  assign pc_plus4 = pc + 32'd4;
  assign redirect = bus.exc_req | bus.eret | bus.jmp | bus.br_taken;

  // Redirects sit above the interlock so a flush during a stall still steers the PC.
  always_comb begin
    pc_next = pc_plus4;
    if (bus.exc_req)       pc_next = EXC_VECTOR;
    else if (bus.eret)     pc_next = bus.epc;
    else if (bus.jmp)      pc_next = bus.jmp_target;
    else if (bus.br_taken) pc_next = bus.br_target;
    else if (!bus.WPC)     pc_next = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  // Flush keeps ID_pc_plus4 so the squashed slot still carries its last link value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ID_inst     <= 32'd0;
      bus.ID_pc_plus4 <= 32'd0;
      bus.ID_valid    <= 1'b0;
      bus.IF_adel     <= 1'b0;
    end else if (redirect) begin
      bus.ID_inst  <= 32'd0;
      bus.ID_valid <= 1'b0;
      bus.IF_adel  <= 1'b0;
    end else if (!bus.ID_stall) begin
      bus.ID_inst     <= bus.imem_rdata;
      bus.ID_pc_plus4 <= pc_plus4;
      bus.ID_valid    <= 1'b1;
      bus.IF_adel     <= (pc[1:0] != 2'b00);
    end
  end

  assign bus.imem_addr = pc[IMEM_AW+1:2];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - bench for if_stage: directed vector table, reset pulse, randomized model run
module tb_if_stage;
  localparam int          AW    = 14;
  localparam logic [31:0] EXC_V = 32'h0000_F000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_stage_if #(.IMEM_AW(AW)) bus();

  if_stage #(.RESET_PC(32'h0), .EXC_VECTOR(EXC_V), .IMEM_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return 32'h1357_9BDF ^ ({18'd0, a} * 32'h9E37_79B1);
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  typedef struct {
    logic        wpc, stall, br, jmp, exc, eret;
    logic [31:0] tgt;
    logic [31:0] exp_pc, exp_pc4, exp_inst;
    logic        exp_valid, exp_adel;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic w, s, b, j, e, r, input logic [31:0] t,
                     input logic [31:0] pc, pc4, inst, input logic v, a);
    vec_t x;
    x.wpc = w; x.stall = s; x.br = b; x.jmp = j; x.exc = e; x.eret = r;
    x.tgt = t; x.exp_pc = pc; x.exp_pc4 = pc4; x.exp_inst = inst;
    x.exp_valid = v; x.exp_adel = a;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] pc, pc4, inst,
                             input logic v, a);
    logic [AW-1:0] exp_addr;
    exp_addr = pc[AW+1:2];
    check({tag, ".imem_addr"}, {18'd0, bus.imem_addr}, {18'd0, exp_addr});
    check({tag, ".pc_plus4"}, bus.ID_pc_plus4, pc4);
    check({tag, ".inst"}, bus.ID_inst, inst);
    check({tag, ".valid"}, {31'd0, bus.ID_valid}, {31'd0, v});
    check({tag, ".adel"}, {31'd0, bus.IF_adel}, {31'd0, a});
  endtask

  task automatic drive(input logic w, s, b, j, e, r, input logic [31:0] bt, jt, ep);
    bus.WPC = w; bus.ID_stall = s; bus.br_taken = b; bus.jmp = j;
    bus.exc_req = e; bus.eret = r; bus.br_target = bt; bus.jmp_target = jt; bus.epc = ep;
  endtask

  // Reference model state (architectural view of pc and the IF/ID slot)
  logic [31:0] m_pc, m_pc4, m_inst;
  logic        m_valid, m_adel;

  initial begin
    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // free run, then stall at 0x10
    add(1,0,0,0,0,0, 0, 32'h04, 32'h04, mem_word(14'h0), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h08, 32'h08, mem_word(14'h1), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h0C, 32'h0C, mem_word(14'h2), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h10, 32'h10, mem_word(14'h3), 1, 0);
    add(0,1,0,0,0,0, 0, 32'h10, 32'h10, mem_word(14'h3), 1, 0);
    add(0,1,0,0,0,0, 0, 32'h10, 32'h10, mem_word(14'h3), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h14, 32'h14, mem_word(14'h4), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h18, 32'h18, mem_word(14'h5), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h1C, 32'h1C, mem_word(14'h6), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h20, 32'h20, mem_word(14'h7), 1, 0);
    // branch, then exception beating jump and interlock, then eret
    add(1,0,1,0,0,0, 32'h100, 32'h100, 32'h20, 0, 0, 0);
    add(1,0,0,0,0,0, 0, 32'h104, 32'h104, mem_word(14'h40), 1, 0);
    add(0,0,0,1,1,0, 32'h40, EXC_V, 32'h104, 0, 0, 0);
    add(1,0,0,0,0,1, 32'h24, 32'h24, 32'h104, 0, 0, 0);
    add(1,0,0,0,0,0, 0, 32'h28, 32'h28, mem_word(14'h9), 1, 0);
    // misaligned jump target, then wrap at the top of the address space
    add(1,0,0,1,0,0, 32'h42, 32'h42, 32'h28, 0, 0, 0);
    add(1,0,0,0,0,0, 0, 32'h46, 32'h46, mem_word(14'h10), 1, 1);
    add(1,0,0,1,0,0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h46, 0, 0, 0);
    add(1,0,0,0,0,0, 0, 32'h0, 32'h0, mem_word(14'h3FFF), 1, 0);
    add(1,0,0,0,0,0, 0, 32'h4, 32'h4, mem_word(14'h0), 1, 0);
    // WPC=0 without stall refetches the same word; redirect during full interlock
    add(0,0,0,0,0,0, 0, 32'h4, 32'h8, mem_word(14'h1), 1, 0);
    add(0,0,0,0,0,0, 0, 32'h4, 32'h8, mem_word(14'h1), 1, 0);
    add(0,1,1,0,0,0, 32'h200, 32'h200, 32'h8, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    check_state("reset", 32'h0, 32'h0, 32'h0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wpc, vecs[i].stall, vecs[i].br, vecs[i].jmp, vecs[i].exc, vecs[i].eret,
            vecs[i].tgt, vecs[i].tgt, vecs[i].tgt);
      @(posedge clk);
      @(negedge clk);
      check_state($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pc4,
                  vecs[i].exp_inst, vecs[i].exp_valid, vecs[i].exp_adel);
    end

    // asynchronous reset pulse between edges at pc=0x200
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_state("async_rst", 32'h0, 32'h0, 32'h0, 0, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_state("post_rst", 32'h4, 32'h4, mem_word(14'h0), 1, 0);

    m_pc = 32'h4; m_pc4 = 32'h4; m_inst = mem_word(14'h0); m_valid = 1'b1; m_adel = 1'b0;

    for (int c = 0; c < 400; c++) begin
      logic        w, s, b, j, e, r, redirect;
      logic [31:0] bt, jt, ep, target;
      logic [31:0] pick [4];
      for (int k = 0; k < 4; k++) begin
        case ($urandom_range(0, 5))
          0:       pick[k] = $urandom();
          1:       pick[k] = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
          2:       pick[k] = {16'd0, 16'($urandom())};
          default: pick[k] = {16'd0, 14'($urandom()), 2'b00};
        endcase
      end
      bt = pick[0]; jt = pick[1]; ep = pick[2];
      w = ($urandom_range(0, 4) != 0);
      s = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 7) == 0);
      j = ($urandom_range(0, 9) == 0);
      e = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 19) == 0);
      drive(w, s, b, j, e, r, bt, jt, ep);

      redirect = e | r | j | b;
      target = e ? EXC_V : r ? ep : j ? jt : bt;
      if (redirect) begin
        m_inst = 32'd0; m_valid = 1'b0; m_adel = 1'b0;
      end else if (!s) begin
        m_inst  = mem_word(m_pc[AW+1:2]);
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_adel  = (m_pc % 4) != 0;
      end
      if (redirect)  m_pc = target;
      else if (w)    m_pc = m_pc + 32'd4;

      @(posedge clk);
      @(negedge clk);
      check_state($sformatf("rnd%0d", c), m_pc, m_pc4, m_inst, m_valid, m_adel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
